// File: rtl/spi_burst_master.sv
// SPI mode-0 burst master: instruction byte, address byte, then 1..MAX_BYTES
// data bytes, MSB first. Optional receive byte stream is compiled in with
// `define SPI_BURST_RX_STREAM_EN (adds rx_valid / rx_byte ports).
module spi_burst_master #(
  parameter int          CLK_DIV   = 2,
  parameter int          MAX_BYTES = 6,
  parameter logic [7:0]  WR_CMD    = 8'h0A,
  parameter logic [7:0]  RD_CMD    = 8'h0B
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           rw,
  input  logic [7:0]                     address,
  input  logic [$clog2(MAX_BYTES+1)-1:0] nbytes,
  input  logic [8*MAX_BYTES-1:0]         wr_data,
  input  logic                           miso,
  output logic                           ss,
  output logic                           sclk,
  output logic                           mosi,
  output logic [8*MAX_BYTES-1:0]         rd_data,
  output logic                           busy,
  output logic                           done
`ifdef SPI_BURST_RX_STREAM_EN
  ,
  output logic                           rx_valid,
  output logic [7:0]                     rx_byte
`endif
);

  localparam int TOT_BITS = 16 + 8*MAX_BYTES;
  localparam int BW       = $clog2(TOT_BITS);
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NBW      = $clog2(MAX_BYTES+1);
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV-1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    rw_q, rw_d;
  logic [NBW-1:0]          n_q, n_d, n_eff;
  logic [TOT_BITS-2:0]     tx_q, tx_d;     // bits still to send after the one on mosi
  logic [TOT_BITS-1:0]     tx_load;
  logic [8*MAX_BYTES-1:0]  rx_q, rx_d;     // last 8*MAX_BYTES sampled bits, newest in LSB
  logic [8*MAX_BYTES-1:0]  rd_asm;
  logic [8*MAX_BYTES-1:0]  rd_data_q, rd_data_d;
  logic [DW-1:0]           div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d, last_bit;
  logic                    ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                    busy_q, busy_d, done_q, done_d;
`ifdef SPI_BURST_RX_STREAM_EN
  logic                    rx_valid_q, rx_valid_d;
  logic [7:0]              rx_byte_q, rx_byte_d;
`endif

  // Clamp requested count to 1..MAX_BYTES and build the outgoing bit vector
  always_comb begin
    if (nbytes == '0)                     n_eff = NBW'(1);
    else if (nbytes > NBW'(MAX_BYTES))    n_eff = NBW'(MAX_BYTES);
    else                                  n_eff = nbytes;
    tx_load = '0;
    tx_load[TOT_BITS-1 -: 16] = {(rw ? RD_CMD : WR_CMD), address};
    for (int i = 0; i < MAX_BYTES; i++)
      tx_load[8*(MAX_BYTES-1-i) +: 8] = rw ? 8'h00 : wr_data[8*i +: 8];
  end

  // Read payload: byte k of N sits 8*(N-1-k) bits up from the newest sample
  always_comb begin
    rd_asm   = rd_data_q;
    last_bit = BW'(15 + 8*int'(n_q));
    for (int k = 0; k < MAX_BYTES; k++)
      if (k < int'(n_q)) rd_asm[8*k +: 8] = rx_q[8*(int'(n_q)-1-k) +: 8];
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    n_d       = n_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    div_d     = div_q;
    bit_d     = bit_q;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SPI_BURST_RX_STREAM_EN
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        rw_d    = rw;
        n_d     = n_eff;
        tx_d    = tx_load[TOT_BITS-2:0];
        mosi_d  = tx_load[TOT_BITS-1];
        ss_d    = 1'b0;
        busy_d  = 1'b1;
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        state_d = SETUP;
      end
      SETUP: if (div_q == DIV_END) begin
        div_d   = '0;
        state_d = SHIFT;
      end else div_d = div_q + 1'b1;
      SHIFT: if (div_q == DIV_END) begin
        div_d = '0;
        if (!sclk_q) begin
          // rising edge: sample miso
          sclk_d = 1'b1;
          rx_d   = {rx_q[8*MAX_BYTES-2:0], miso};
`ifdef SPI_BURST_RX_STREAM_EN
          if (rw_q && bit_q >= BW'(16) && bit_q[2:0] == 3'd7) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = {rx_q[6:0], miso};
          end
`endif
        end else begin
          // falling edge: advance mosi or finish
          sclk_d = 1'b0;
          if (bit_q == last_bit) begin
            mosi_d  = 1'b0;
            if (rw_q) rd_data_d = rd_asm;
            state_d = HOLD;
          end else begin
            bit_d  = bit_q + 1'b1;
            mosi_d = tx_q[TOT_BITS-2];
            tx_d   = {tx_q[TOT_BITS-3:0], 1'b0};
          end
        end
      end else div_d = div_q + 1'b1;
      HOLD: if (div_q == DIV_END) begin
        div_d   = '0;
        ss_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end else div_d = div_q + 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transfer without done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rw_q      <= 1'b0;
      n_q       <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      ss_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_BURST_RX_STREAM_EN
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      n_q       <= n_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SPI_BURST_RX_STREAM_EN
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
`endif
    end
  end

  assign ss      = ss_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef SPI_BURST_RX_STREAM_EN
  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;
`endif

endmodule

// File: tb/tb_spi_burst_master.sv
// Directed bench for spi_burst_master (CLK_DIV=2, MAX_BYTES=6) with a
// mode-0 slave model that shifts a preset byte table out on miso.
module tb_spi_burst_master;
  localparam int CLK_DIV = 2;
  localparam int MAX_BYTES = 6;

  logic        clk = 1'b0;
  logic        reset, start, rw, miso;
  logic [7:0]  address;
  logic [2:0]  nbytes;
  logic [47:0] wr_data, rd_data;
  logic        ss, sclk, mosi, busy, done;
`ifdef SPI_BURST_RX_STREAM_EN
  logic        rx_valid;
  logic [7:0]  rx_byte;
`endif

  spi_burst_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .address(address),
    .nbytes(nbytes), .wr_data(wr_data), .miso(miso), .ss(ss), .sclk(sclk),
    .mosi(mosi), .rd_data(rd_data), .busy(busy), .done(done)
`ifdef SPI_BURST_RX_STREAM_EN
    , .rx_valid(rx_valid), .rx_byte(rx_byte)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // bus monitors
  int           pulses   = 0;
  logic [127:0] mosi_sh  = '0;
  int           done_cnt = 0;
  always @(posedge sclk) begin
    pulses  = pulses + 1;
    mosi_sh = {mosi_sh[126:0], mosi};
  end
  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

`ifdef SPI_BURST_RX_STREAM_EN
  logic [7:0] rxq[$];
  time        rxt[$];
  always @(negedge clk) if (rx_valid === 1'b1) begin
    rxq.push_back(rx_byte);
    rxt.push_back($time);
  end
`endif

  // slave: bit p of the transaction (0-based) is zero for cmd/addr, then data MSB first
  int          base_p = 0;
  int          sp;
  logic [47:0] slv_data = '0;
  always_comb begin
    sp   = pulses - base_p;
    miso = 1'b0;
    if (sp >= 16 && sp < 16 + 8*MAX_BYTES)
      miso = slv_data[8*((sp-16)/8) + 7 - ((sp-16)%8)];
  end

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run(input logic r, input logic [7:0] a, input logic [2:0] n,
                     input logic [47:0] wd, input string tag, output int np, output int nd);
    logic ok;
    int   d0;
    @(negedge clk);
    base_p = pulses; d0 = done_cnt;
    rw = r; address = a; nbytes = n; wr_data = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done(ok);
    chk({tag, "_done_seen"}, {63'd0, ok}, 64'd1);
    repeat (2) @(negedge clk);
    np = pulses - base_p;
    nd = done_cnt - d0;
  endtask

  initial begin
    int np, nd, d0, rxb;
    logic ok;
    reset = 1'b1; start = 1'b0; rw = 1'b0; address = '0; nbytes = '0; wr_data = '0;
    #12;
    chk("rst_ss",   {63'd0, ss},   64'd1);
    chk("rst_sclk", {63'd0, sclk}, 64'd0);
    chk("rst_mosi", {63'd0, mosi}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_rd",   {16'd0, rd_data}, 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    // six-byte read
    slv_data = 48'h665544332211;
`ifdef SPI_BURST_RX_STREAM_EN
    rxb = rxq.size();
`else
    rxb = 0;
`endif
    run(1'b1, 8'h08, 3'd6, 48'hFFFF_FFFF_FFFF, "rd6", np, nd);
    chk("rd6_pulses", 64'(np), 64'd64);
    chk("rd6_dones",  64'(nd), 64'd1);
    chk("rd6_rd",     {16'd0, rd_data}, 64'h0000_6655_4433_2211);
    chk("rd6_mosi",   mosi_sh[63:0], 64'h0B08_0000_0000_0000);
    chk("rd6_ss",     {63'd0, ss}, 64'd1);
`ifdef SPI_BURST_RX_STREAM_EN
    chk("rx_count", 64'(rxq.size() - rxb), 64'd6);
    for (int k = 0; k < 6 && rxb + k < rxq.size(); k++) begin
      chk("rx_byte", {56'd0, rxq[rxb+k]}, 64'(8'h11 * (k+1)));
      if (k > 0) chk("rx_gap", 64'(rxt[rxb+k] - rxt[rxb+k-1]), 64'(2*CLK_DIV*8*10));
    end
    rxb = rxq.size();
`endif

    // one-byte write; rd_data must keep the read result
    run(1'b0, 8'h2D, 3'd1, 48'h0000_0000_0002, "wr1", np, nd);
    chk("wr1_pulses", 64'(np), 64'd24);
    chk("wr1_dones",  64'(nd), 64'd1);
    chk("wr1_mosi",   {40'd0, mosi_sh[23:0]}, 64'h0A2D02);
    chk("wr1_rd",     {16'd0, rd_data}, 64'h0000_6655_4433_2211);
`ifdef SPI_BURST_RX_STREAM_EN
    chk("wr_no_rx", 64'(rxq.size() - rxb), 64'd0);
`endif

    // nbytes=0 read acts as one byte; only rd byte 0 changes
    slv_data = 48'h0000_0000_00A5;
    run(1'b1, 8'h3C, 3'd0, 48'h0, "rd0", np, nd);
    chk("rd0_pulses", 64'(np), 64'd24);
    chk("rd0_mosi",   {40'd0, mosi_sh[23:0]}, 64'h0B3C00);
    chk("rd0_rd",     {16'd0, rd_data}, 64'h0000_6655_4433_22A5);

    // nbytes=7 write clamps to six bytes
    run(1'b0, 8'h55, 3'd7, 48'hCCBB_AA99_8877, "wr7", np, nd);
    chk("wr7_pulses", 64'(np), 64'd64);
    chk("wr7_mosi",   mosi_sh[63:0], 64'h0A55_7788_99AA_BBCC);
    chk("wr7_rd",     {16'd0, rd_data}, 64'h0000_6655_4433_22A5);

    // start held high: one transaction, then the next one starts after done
    @(negedge clk);
    base_p = pulses; d0 = done_cnt;
    rw = 1'b0; address = 8'h11; nbytes = 3'd1; wr_data = 48'h0000_0000_0033; start = 1'b1;
    wait_done(ok);
    chk("hold_done_seen", {63'd0, ok}, 64'd1);
    chk("hold_busy_done", {63'd0, busy}, 64'd0);
    chk("hold_ss_done",   {63'd0, ss}, 64'd1);
    @(negedge clk);
    chk("hold_pulses",    64'(pulses - base_p), 64'd24);
    chk("hold_dones",     64'(done_cnt - d0), 64'd1);
    chk("hold_ss_gap",    {63'd0, ss}, 64'd1);
    @(negedge clk);
    chk("hold_restart_busy", {63'd0, busy}, 64'd1);
    chk("hold_restart_ss",   {63'd0, ss}, 64'd0);
    start = 1'b0;
    wait_done(ok);
    chk("hold2_done_seen", {63'd0, ok}, 64'd1);
    repeat (2) @(negedge clk);

    // reset during bit 20 of a read
    slv_data = 48'h665544332211;
    @(negedge clk);
    base_p = pulses;
    rw = 1'b1; address = 8'h08; nbytes = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (pulses - base_p >= 20) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("abort_reached", {63'd0, ok}, 64'd1);
    chk("abort_sclk_hi", {63'd0, sclk}, 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_ss",   {63'd0, ss},   64'd1);
    chk("abort_sclk", {63'd0, sclk}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_rd",   {16'd0, rd_data}, 64'd0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_idle_ss", {63'd0, ss}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
